vc_allocator: RTL and testbench
===============================

Name: vc_allocator

Overview:
Output-VC allocator for the router pipeline. It tracks which VCs are occupied on every output port. Each cycle it grants at most one free output VC per output port to a requesting input VC, using round-robin arbitration. It frees a VC when the downstream tail flit departs. The resulting per-port VC busy map is exported to the switch allocator and the credit logic.

Parameters:
PORT_NUM, 5, number of router ports (input and output)
VC_NUM, 4, VCs per port
Derived: PW = $clog2(PORT_NUM); VW = $clog2(VC_NUM); NIN = PORT_NUM*VC_NUM

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NIN  input VC i (i = port*VC_NUM+vc) requests an output VC
req_outport  in  NIN*PW  target output port of input VC i, slice [i*PW +: PW]
grant  out  NIN  registered one-cycle grant pulse per input VC
grant_vc  out  NIN*VW  allocated output VC id, valid only while grant[i]=1
release_valid  in  PORT_NUM  tail flit left output port p; free one VC
release_vc  in  PORT_NUM*VW  VC id freed on port p
vc_busy  out  PORT_NUM*VC_NUM  occupancy, bit p*VC_NUM+v
err_release  out  1  sticky; set when a release targets a non-busy VC

Behaviour:
- Reset (async, any cycle, including mid-allocation): all outputs = 0, all round-robin pointers = 0. No grant in the cycle after reset deassertion unless a request was sampled at that edge.
- Requester protocol:
  - req_valid[i] and req_outport stay stable until grant[i] is seen.
  - The requester deasserts req_valid[i] in the cycle after the grant.
  - The allocator masks req_valid[i] while grant[i]=1, so a held request is never double-granted.
- Candidates for output port p: req_valid[i] & ~grant[i] & (req_outport[i]==p). Out-of-range outport values (>= PORT_NUM) are ignored.
- Free set for port p: ~vc_busy[p] sampled at the start of the cycle. A VC released this cycle becomes allocatable only from the next cycle.
- Arbitration per port:
  - If there is at least one candidate and at least one free VC, the winner is the first candidate at index >= rr_ptr[p], wrapping modulo NIN.
  - The allocated VC is the lowest-index free VC.
  - If there is no candidate or no free VC: no grant, and the pointer holds.
- Latency: a request sampled at edge N produces grant at N+1 (registered). vc_busy sets at the same edge N+1.
- Pointer update: on grant, rr_ptr[p] = (winner+1) mod NIN. The pointer holds otherwise.
- Ports are independent. Up to PORT_NUM grants can fire in one cycle, each to a distinct input VC. An input VC targets exactly one port, so there is no cross-port conflict.
- Release: if release_valid[p] is high, vc_busy[p][release_vc[p]] clears at the next edge.
- Same cycle, same port, allocation of VC a and release of VC b: both apply. a != b by construction, because a was free.
- Release of a non-busy VC: busy state unchanged, err_release set; only rst clears it.
- Port full (vc_busy[p] all ones): requests wait indefinitely and stay pending. There is no timeout.

Decomposition:
- noc_pkg holds:
  - PORT_NUM and VC_NUM defaults
  - the PW/VW/NIN width functions
  - typedefs port_id_t and vc_id_t
- Sub-module rr_arbiter: N-bit request vector in, one-hot grant plus encoded index out, pointer register updated on an enable. It is instantiated once per output port with N = NIN.
- Lowest-free-VC selection is a small priority encoder kept inline.

Test Plan:
1. Reset mid-operation: grants and busy bits pending, assert rst asynchronously mid-cycle -> grant, grant_vc, vc_busy and err_release are 0 immediately and all pointers are back at 0.
2. Single request: req_valid[0]=1, outport 2 at edge 0 -> edge 1: grant[0]=1, grant_vc[0]=0, vc_busy port 2 = 4'b0001; requester drops req -> no second grant at edge 2.
3. Contention: inputs 1, 5 and 9 request outport 3 simultaneously and hold until granted -> grants at edges 1, 2 and 3 to inputs 1, 5, 9 with grant_vc 0, 1, 2; port-3 pointer ends at 10.
4. Port full plus release: port 1 busy = 4'b1111, input 6 requests and stalls -> release_vc=2 at edge k clears bit 2 at k; grant[6] with grant_vc=2 at edge k+1.
5. Parallel ports: inputs 0→port 4 and 12→port 0 in the same cycle -> both grants at edge 1, each with grant_vc=0.
6. Bad release: release_valid[0]=1, vc 3, with port 0 idle -> vc_busy unchanged, err_release=1 and held until rst.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router parameters, width helpers and id typedefs.
package noc_pkg;

    localparam int unsigned PORT_NUM_DEF = 5;
    localparam int unsigned VC_NUM_DEF   = 4;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    function automatic int unsigned pw_f(input int unsigned port_num);
        return clog2_min1(port_num);
    endfunction

    function automatic int unsigned vw_f(input int unsigned vc_num);
        return clog2_min1(vc_num);
    endfunction

    function automatic int unsigned nin_f(input int unsigned port_num, input int unsigned vc_num);
        return port_num * vc_num;
    endfunction

    typedef logic [pw_f(PORT_NUM_DEF)-1:0] port_id_t;
    typedef logic [vw_f(VC_NUM_DEF)-1:0]   vc_id_t;

endpackage

// File: rtl/vc_allocator_if.sv
// Request/grant/release bundle between input VCs and the output-VC allocator.
interface vc_allocator_if
    import noc_pkg::*;
#(
    parameter int unsigned PORT_NUM = PORT_NUM_DEF,
    parameter int unsigned VC_NUM   = VC_NUM_DEF
);

    localparam int unsigned PW  = pw_f(PORT_NUM);
    localparam int unsigned VW  = vw_f(VC_NUM);
    localparam int unsigned NIN = nin_f(PORT_NUM, VC_NUM);

    logic [NIN-1:0]             req_valid;
    logic [NIN*PW-1:0]          req_outport;
    logic [NIN-1:0]             grant;
    logic [NIN*VW-1:0]          grant_vc;
    logic [PORT_NUM-1:0]        release_valid;
    logic [PORT_NUM*VW-1:0]     release_vc;
    logic [PORT_NUM*VC_NUM-1:0] vc_busy;
    logic                       err_release;

    // Requester / downstream side.
    modport master (
        output req_valid,
        output req_outport,
        output release_valid,
        output release_vc,
        input  grant,
        input  grant_vc,
        input  vc_busy,
        input  err_release
    );

    // Allocator side.
    modport slave (
        input  req_valid,
        input  req_outport,
        input  release_valid,
        input  release_vc,
        output grant,
        output grant_vc,
        output vc_busy,
        output err_release
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins, wrapping modulo N.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned N = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_i,
    input  logic                     en_i,
    output logic [N-1:0]             gnt_c_o,
    output logic [clog2_min1(N)-1:0] idx_c_o,
    output logic                     valid_c_o
);

    localparam int unsigned IW = clog2_min1(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    int unsigned   scan_idx;

    // Search from the pointer upward with wrap-around.
    always_comb begin
        gnt_c_o   = '0;
        idx_c_o   = '0;
        valid_c_o = 1'b0;
        scan_idx  = 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!valid_c_o && req_i[scan_idx]) begin
                valid_c_o         = 1'b1;
                gnt_c_o[scan_idx] = 1'b1;
                idx_c_o           = IW'(scan_idx);
            end
        end
    end

    // Pointer moves past the winner only when the grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && valid_c_o) begin
            if (32'(idx_c_o) == N - 32'd1) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_c_o + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// Output-VC allocator: per-port round-robin grant of the lowest free VC, plus
// busy-map tracking with tail-flit release and a sticky bad-release flag.
module vc_allocator
    import noc_pkg::*;
#(
    parameter int unsigned PORT_NUM = PORT_NUM_DEF,
    parameter int unsigned VC_NUM   = VC_NUM_DEF
) (
    input  logic          clk,
    input  logic          rst,
    vc_allocator_if.slave alloc_if
);

    localparam int unsigned PW  = pw_f(PORT_NUM);
    localparam int unsigned VW  = vw_f(VC_NUM);
    localparam int unsigned NIN = nin_f(PORT_NUM, VC_NUM);
    localparam int unsigned IW  = clog2_min1(NIN);

    logic [NIN-1:0]             grant_q;
    logic [NIN-1:0]             grant_d;
    logic [NIN*VW-1:0]          grant_vc_q;
    logic [NIN*VW-1:0]          grant_vc_d;
    logic [PORT_NUM*VC_NUM-1:0] vc_busy_q;
    logic [PORT_NUM*VC_NUM-1:0] vc_busy_d;
    logic                       err_release_q;
    logic                       err_release_d;

    logic [PORT_NUM-1:0][NIN-1:0] cand_c;
    logic [PORT_NUM-1:0][NIN-1:0] arb_gnt_c;
    logic [PORT_NUM-1:0][IW-1:0]  arb_idx_c;
    logic [PORT_NUM-1:0]          arb_valid_c;
    logic [PORT_NUM-1:0]          has_free_c;
    logic [PORT_NUM-1:0][VW-1:0]  low_free_c;
    int unsigned                  rel_vc;
    int unsigned                  rel_bit;

    // Candidates per port; a request is masked while its grant pulse is showing.
    always_comb begin
        cand_c = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned i = 0; i < NIN; i++) begin
                cand_c[p][i] = alloc_if.req_valid[i] & ~grant_q[i] &
                               (alloc_if.req_outport[i*PW +: PW] == PW'(p));
            end
        end
    end

    // Lowest-index free VC per port, from the registered busy map.
    always_comb begin
        has_free_c = '0;
        low_free_c = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            has_free_c[p] = ~&vc_busy_q[p*VC_NUM +: VC_NUM];
            for (int v = int'(VC_NUM) - 1; v >= 0; v--) begin
                if (!vc_busy_q[p*VC_NUM + 32'(v)]) begin
                    low_free_c[p] = VW'(v);
                end
            end
        end
    end

    for (genvar gp = 0; gp < int'(PORT_NUM); gp++) begin : g_port_arb
        rr_arbiter #(
            .N (NIN)
        ) u_rr_arbiter (
            .clk       (clk),
            .rst       (rst),
            .req_i     (cand_c[gp]),
            .en_i      (has_free_c[gp]),
            .gnt_c_o   (arb_gnt_c[gp]),
            .idx_c_o   (arb_idx_c[gp]),
            .valid_c_o (arb_valid_c[gp])
        );
    end

    // Release is evaluated against the old map, then the new allocation is set;
    // the allocated VC was free so it can never collide with a valid release.
    always_comb begin
        grant_d       = '0;
        grant_vc_d    = '0;
        vc_busy_d     = vc_busy_q;
        err_release_d = err_release_q;
        rel_vc        = 32'd0;
        rel_bit       = 32'd0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (alloc_if.release_valid[p]) begin
                rel_vc  = 32'(alloc_if.release_vc[p*VW +: VW]);
                rel_bit = p*VC_NUM + rel_vc;
                if (rel_vc < VC_NUM && vc_busy_q[rel_bit]) begin
                    vc_busy_d[rel_bit] = 1'b0;
                end else begin
                    err_release_d = 1'b1;
                end
            end
            if (arb_valid_c[p] && has_free_c[p]) begin
                grant_d = grant_d | arb_gnt_c[p];
                grant_vc_d[32'(arb_idx_c[p])*VW +: VW] = low_free_c[p];
                vc_busy_d[p*VC_NUM + 32'(low_free_c[p])] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q       <= '0;
            grant_vc_q    <= '0;
            vc_busy_q     <= '0;
            err_release_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            grant_vc_q    <= grant_vc_d;
            vc_busy_q     <= vc_busy_d;
            err_release_q <= err_release_d;
        end
    end

    assign alloc_if.grant       = grant_q;
    assign alloc_if.grant_vc    = grant_vc_q;
    assign alloc_if.vc_busy     = vc_busy_q;
    assign alloc_if.err_release = err_release_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Scoreboard bench for vc_allocator: directed requests push expected grants,
// a negedge monitor pops and compares every grant the DUT shows.
module tb_vc_allocator;
    import noc_pkg::*;

    localparam int unsigned PORT_NUM = 5;
    localparam int unsigned VC_NUM   = 4;
    localparam int unsigned PW       = pw_f(PORT_NUM);
    localparam int unsigned VW       = vw_f(VC_NUM);
    localparam int unsigned NIN      = nin_f(PORT_NUM, VC_NUM);

    typedef struct {
        int unsigned cyc;
        int unsigned idx;
        int unsigned vc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned mon_vc;
    int unsigned c;

    vc_allocator_if #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM)) vif ();

    vc_allocator #(
        .PORT_NUM (PORT_NUM),
        .VC_NUM   (VC_NUM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alloc_if (vif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Grant monitor: every grant seen must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NIN); i++) begin
                if (vif.grant[i]) begin
                    mon_vc = 32'(vif.grant_vc[i*VW +: VW]);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_grant: in=%0d vc=%0d cycle=%0d, none expected",
                                 i, mon_vc, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.idx == 32'(i) && mon_e.vc == mon_vc && mon_e.cyc == cyc) begin
                            n_pass++;
                        end else begin
                            $display("FAIL grant: got in=%0d vc=%0d cycle=%0d expected in=%0d vc=%0d cycle=%0d",
                                     i, mon_vc, cyc, mon_e.idx, mon_e.vc, mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    // Advance one edge; requesters drop req in the cycle after their grant.
    task automatic tick();
        @(posedge clk);
        #1;
        vif.req_valid = vif.req_valid & ~vif.grant;
    endtask

    task automatic set_req(input int unsigned i, input int unsigned port);
        vif.req_valid[i] = 1'b1;
        vif.req_outport[i*PW +: PW] = PW'(port);
    endtask

    task automatic set_rel(input int unsigned p, input int unsigned vc);
        vif.release_valid[p] = 1'b1;
        vif.release_vc[p*VW +: VW] = VW'(vc);
    endtask

    task automatic push(input int unsigned idx, input int unsigned vc, input int unsigned at);
        exp_t e;
        e.cyc = at;
        e.idx = idx;
        e.vc  = vc;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for all expected grants to be observed.
    task automatic drain(input int unsigned budget);
        int unsigned n;
        exp_t e;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL grant_timeout: in=%0d vc=%0d expected at cycle %0d, no grant seen",
                     e.idx, e.vc, e.cyc);
        end
    endtask

    task automatic do_reset();
        vif.req_valid     = '0;
        vif.release_valid = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.req_valid     = '0;
        vif.req_outport   = '0;
        vif.release_valid = '0;
        vif.release_vc    = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_grant", 32'(vif.grant), 32'h0);
        chk("reset_grant_vc", 32'(vif.grant_vc[31:0]), 32'h0);
        chk("reset_busy", 32'(vif.vc_busy), 32'h0);
        chk("reset_err", 32'(vif.err_release), 32'h0);
        rst = 1'b0;
        tick();

        // Mid-operation async reset clears outputs immediately and rewinds pointers.
        set_req(3, 0);
        set_req(10, 3);
        set_rel(4, 1);
        tick();
        vif.release_valid = '0;
        chk("t1_busy_pre", 32'(vif.vc_busy), 32'h0000_1001);
        chk("t1_err_pre", 32'(vif.err_release), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t1_grant_rst", 32'(vif.grant), 32'h0);
        chk("t1_grant_vc_rst", vif.grant_vc[31:0], 32'h0);
        chk("t1_busy_rst", 32'(vif.vc_busy), 32'h0);
        chk("t1_err_rst", 32'(vif.err_release), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        c = cyc;
        set_req(2, 0);
        set_req(15, 0);
        push(2, 0, c + 1);
        push(15, 1, c + 2);
        drain(8);

        // Single request, no double grant after the requester drops.
        do_reset();
        c = cyc;
        set_req(0, 2);
        push(0, 0, c + 1);
        tick();
        chk("t2_busy", 32'(vif.vc_busy), 32'h0000_0100);
        tick();
        tick();
        drain(4);

        // Contention on port 3, then pointer at 10 favours input 11 over 0.
        do_reset();
        c = cyc;
        set_req(1, 3);
        set_req(5, 3);
        set_req(9, 3);
        push(1, 0, c + 1);
        push(5, 1, c + 2);
        push(9, 2, c + 3);
        drain(10);
        chk("t3_busy", 32'(vif.vc_busy), 32'h0000_7000);
        c = cyc;
        set_req(0, 3);
        set_req(11, 3);
        push(11, 3, c + 1);
        push(0, 1, c + 3);
        tick();
        set_rel(3, 1);
        tick();
        vif.release_valid = '0;
        chk("t3_busy_release", 32'(vif.vc_busy), 32'h0000_D000);
        drain(6);
        chk("t3_busy_full", 32'(vif.vc_busy), 32'h0000_F000);

        // Port full: request stalls until a release, granted one edge later.
        do_reset();
        c = cyc;
        for (int unsigned i = 0; i < 4; i++) begin
            set_req(i, 1);
            push(i, i, c + 1 + i);
        end
        drain(10);
        chk("t4_busy_full", 32'(vif.vc_busy), 32'h0000_00F0);
        set_req(6, 1);
        tick();
        tick();
        tick();
        chk("t4_busy_stall", 32'(vif.vc_busy), 32'h0000_00F0);
        set_rel(1, 2);
        push(6, 2, cyc + 2);
        tick();
        vif.release_valid = '0;
        chk("t4_busy_release", 32'(vif.vc_busy), 32'h0000_00B0);
        drain(6);
        chk("t4_busy_regrant", 32'(vif.vc_busy), 32'h0000_00F0);

        // Parallel ports in one cycle; out-of-range outport is ignored.
        do_reset();
        c = cyc;
        set_req(0, 4);
        set_req(12, 0);
        set_req(5, 6);
        push(0, 0, c + 1);
        push(12, 0, c + 1);
        drain(6);
        tick();
        tick();
        chk("t5_busy", 32'(vif.vc_busy), 32'h0001_0001);
        vif.req_valid[5] = 1'b0;

        // Release of a non-busy VC: map unchanged, sticky error until reset.
        set_rel(0, 3);
        tick();
        vif.release_valid = '0;
        chk("t6_busy", 32'(vif.vc_busy), 32'h0001_0001);
        chk("t6_err", 32'(vif.err_release), 32'h1);
        tick();
        tick();
        tick();
        chk("t6_err_sticky", 32'(vif.err_release), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t6_err_rst", 32'(vif.err_release), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
